// File: rtl/mandel_frame_scheduler.sv
// Raster-scan point sequencer for two Mandelbrot iteration engines.
// Points are issued to the lanes in turn (round-robin) and results leave in raster order
// through a single-entry valid/ready output register.
module mandel_frame_scheduler #(
    parameter int unsigned FIXED_POINT_WIDTH = 16,
    parameter int unsigned ITER_WIDTH        = 8,
    parameter int unsigned H_RES             = 160,
    parameter int unsigned V_RES             = 120,
    localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1,
    localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           frame_start,
    input  logic [FIXED_POINT_WIDTH-1:0]   cfg_x0,
    input  logic [FIXED_POINT_WIDTH-1:0]   cfg_y0,
    input  logic [FIXED_POINT_WIDTH-1:0]   cfg_dx,
    input  logic [FIXED_POINT_WIDTH-1:0]   cfg_dy,
    output logic                           busy,
    output logic                           frame_done,
    output logic [1:0]                     eng_start,
    output logic [FIXED_POINT_WIDTH-1:0]   eng_c_real,
    output logic [FIXED_POINT_WIDTH-1:0]   eng_c_imag,
    input  logic [1:0]                     eng_valid,
    input  logic [1:0]                     eng_is_mandelbrot,
    input  logic [2*ITER_WIDTH-1:0]        eng_iterations,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic [XW-1:0]                  pix_x,
    output logic [YW-1:0]                  pix_y,
    output logic [ITER_WIDTH-1:0]          pix_iterations,
    output logic                           pix_is_mandelbrot,
    output logic                           pix_last
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    localparam logic [2:0] LnFree  = 3'd0;
    localparam logic [2:0] LnArmed = 3'd1;
    localparam logic [2:0] LnWait  = 3'd2;
    localparam logic [2:0] LnBusy  = 3'd3;
    localparam logic [2:0] LnDone  = 3'd4;

    localparam logic [XW-1:0] LastCol = XW'(H_RES - 1);
    localparam logic [YW-1:0] LastRow = YW'(V_RES - 1);

    logic [1:0]                   state_q, state_d;
    logic [FIXED_POINT_WIDTH-1:0] x0_q, dx_q, dy_q;
    logic [XW-1:0]                col_q;
    logic [YW-1:0]                row_q;
    logic [FIXED_POINT_WIDTH-1:0] re_q, im_q;
    logic                         issue_ptr_q, retire_ptr_q;
    logic [FIXED_POINT_WIDTH-1:0] c_real_q, c_imag_q;
    logic                         frame_done_q;

    logic [2:0]            lane_st_q [2];
    logic [2:0]            lane_st_d [2];
    logic [XW-1:0]         lane_x_q  [2];
    logic [YW-1:0]         lane_y_q  [2];
    logic [ITER_WIDTH-1:0] lane_it_q [2];
    logic                  lane_mb_q [2];

    logic                  out_valid_q;
    logic [XW-1:0]         out_x_q;
    logic [YW-1:0]         out_y_q;
    logic [ITER_WIDTH-1:0] out_it_q;
    logic                  out_mb_q;
    logic                  out_last_q;

    logic                         starting;
    logic [XW-1:0]                cur_col;
    logic [YW-1:0]                cur_row;
    logic [FIXED_POINT_WIDTH-1:0] cur_re, cur_im, cur_x0, cur_dx, cur_dy;
    logic                         issue, retire, col_wrap, last_pt, out_free, last_hs;
    logic [1:0]                   issue_vec, retire_vec;
    logic [XW-1:0]                ret_x;
    logic [YW-1:0]                ret_y;

    // The very first point is issued on the frame_start edge itself, straight from the cfg
    // inputs, so the first engine start appears in the cycle after the pulse.
    always_comb begin
        starting = (state_q == StIdle) && frame_start;
        cur_col  = starting ? '0     : col_q;
        cur_row  = starting ? '0     : row_q;
        cur_re   = starting ? cfg_x0 : re_q;
        cur_im   = starting ? cfg_y0 : im_q;
        cur_x0   = starting ? cfg_x0 : x0_q;
        cur_dx   = starting ? cfg_dx : dx_q;
        cur_dy   = starting ? cfg_dy : dy_q;
        col_wrap = (cur_col == LastCol);
        last_pt  = col_wrap && (cur_row == LastRow);
        issue    = (starting || (state_q == StRun)) && (lane_st_q[issue_ptr_q] == LnFree);
        out_free = !out_valid_q || pix_ready;
        retire   = (lane_st_q[retire_ptr_q] == LnDone) && out_free;
        last_hs  = out_valid_q && pix_ready && out_last_q;
        issue_vec  = issue  ? (issue_ptr_q  ? 2'b10 : 2'b01) : 2'b00;
        retire_vec = retire ? (retire_ptr_q ? 2'b10 : 2'b01) : 2'b00;
        ret_x    = lane_x_q[retire_ptr_q];
        ret_y    = lane_y_q[retire_ptr_q];
    end

    // Frame-level sequencing: run until the last point is issued, then drain results.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (frame_start) state_d = StRun;
            StRun:   if (issue && last_pt) state_d = StDrain;
            StDrain: if (last_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Per-lane handshake with its engine; WAIT masks the engine's stale valid from the
    // previous point, and DONE holds until the lane's turn to retire comes round.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            lane_st_d[l] = lane_st_q[l];
            unique case (lane_st_q[l])
                LnFree:  if (issue_vec[l]) lane_st_d[l] = LnArmed;
                LnArmed: lane_st_d[l] = LnWait;
                LnWait:  lane_st_d[l] = LnBusy;
                LnBusy:  if (eng_valid[l]) lane_st_d[l] = LnDone;
                LnDone:  if (retire_vec[l]) lane_st_d[l] = LnFree;
                default: lane_st_d[l] = LnFree;
            endcase
        end
    end

    // Frame state, latched config, raster coordinate / c generator and lane pointers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= StIdle;
            x0_q         <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            re_q         <= '0;
            im_q         <= '0;
            issue_ptr_q  <= 1'b0;
            retire_ptr_q <= 1'b0;
            c_real_q     <= '0;
            c_imag_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= (state_q == StDrain) && last_hs;
            if (starting) begin
                x0_q <= cfg_x0;
                dx_q <= cfg_dx;
                dy_q <= cfg_dy;
            end
            if (issue) begin
                c_real_q    <= cur_re;
                c_imag_q    <= cur_im;
                issue_ptr_q <= ~issue_ptr_q;
                if (col_wrap) begin
                    col_q <= '0;
                    re_q  <= cur_x0;
                    row_q <= cur_row + YW'(1);
                    im_q  <= cur_im + cur_dy;
                end else begin
                    col_q <= cur_col + XW'(1);
                    re_q  <= cur_re + cur_dx;
                    row_q <= cur_row;
                    im_q  <= cur_im;
                end
            end else if (starting) begin
                col_q <= '0;
                row_q <= '0;
                re_q  <= cfg_x0;
                im_q  <= cfg_y0;
            end
            if (retire) begin
                retire_ptr_q <= ~retire_ptr_q;
            end
        end
    end

    // Lane state plus the point coordinates and result each lane is holding.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int l = 0; l < 2; l++) begin
                lane_st_q[l] <= LnFree;
                lane_x_q[l]  <= '0;
                lane_y_q[l]  <= '0;
                lane_it_q[l] <= '0;
                lane_mb_q[l] <= 1'b0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                lane_st_q[l] <= lane_st_d[l];
                if (issue_vec[l]) begin
                    lane_x_q[l] <= cur_col;
                    lane_y_q[l] <= cur_row;
                end
                // Capture on arrival: the engine may drop valid before this lane retires.
                if ((lane_st_q[l] == LnBusy) && eng_valid[l]) begin
                    lane_it_q[l] <= eng_iterations[l*ITER_WIDTH +: ITER_WIDTH];
                    lane_mb_q[l] <= eng_is_mandelbrot[l];
                end
            end
        end
    end

    // Output register: loads on retire (also while draining), otherwise empties on accept.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_it_q    <= '0;
            out_mb_q    <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (retire) begin
            out_valid_q <= 1'b1;
            out_x_q     <= ret_x;
            out_y_q     <= ret_y;
            out_it_q    <= lane_it_q[retire_ptr_q];
            out_mb_q    <= lane_mb_q[retire_ptr_q];
            out_last_q  <= (ret_x == LastCol) && (ret_y == LastRow);
        end else if (pix_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

    // Output drive.
    always_comb begin
        busy              = (state_q != StIdle);
        frame_done        = frame_done_q;
        eng_start         = {lane_st_q[1] == LnArmed, lane_st_q[0] == LnArmed};
        eng_c_real        = c_real_q;
        eng_c_imag        = c_imag_q;
        pix_valid         = out_valid_q;
        pix_x             = out_x_q;
        pix_y             = out_y_q;
        pix_iterations    = out_it_q;
        pix_is_mandelbrot = out_mb_q;
        pix_last          = out_last_q;
    end

endmodule

// File: tb/tb_mandel_frame_scheduler.sv
// Directed bench for mandel_frame_scheduler on a 4x2 grid with a latency-programmable
// engine model per lane.
module tb_mandel_frame_scheduler;

    localparam int FPW = 16;
    localparam int IW  = 8;
    localparam int HR  = 4;
    localparam int VR  = 2;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic           frame_start = 1'b0;
    logic [FPW-1:0] cfg_x0 = '0, cfg_y0 = '0, cfg_dx = '0, cfg_dy = '0;
    logic           busy, frame_done;
    logic [1:0]     eng_start;
    logic [FPW-1:0] eng_c_real, eng_c_imag;
    logic [1:0]     eng_valid, eng_is_mandelbrot;
    logic [2*IW-1:0] eng_iterations;
    logic           pix_valid;
    logic           pix_ready = 1'b1;
    logic [1:0]     pix_x;
    logic [0:0]     pix_y;
    logic [IW-1:0]  pix_iterations;
    logic           pix_is_mandelbrot, pix_last;

    always #5 clk = ~clk;

    mandel_frame_scheduler #(
        .FIXED_POINT_WIDTH(FPW),
        .ITER_WIDTH(IW),
        .H_RES(HR),
        .V_RES(VR)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .frame_start(frame_start),
        .cfg_x0(cfg_x0),
        .cfg_y0(cfg_y0),
        .cfg_dx(cfg_dx),
        .cfg_dy(cfg_dy),
        .busy(busy),
        .frame_done(frame_done),
        .eng_start(eng_start),
        .eng_c_real(eng_c_real),
        .eng_c_imag(eng_c_imag),
        .eng_valid(eng_valid),
        .eng_is_mandelbrot(eng_is_mandelbrot),
        .eng_iterations(eng_iterations),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .pix_iterations(pix_iterations),
        .pix_is_mandelbrot(pix_is_mandelbrot),
        .pix_last(pix_last)
    );

    // Engine model: valid drops when a start is seen and rises lat cycles later (level).
    // Result is c_real[15:8]^c_imag[15:8], or in-set with FF when ovr is set for the lane.
    int             lat [2];
    logic [1:0]     ovr = 2'b00;
    int             mcnt [2];
    logic [FPW-1:0] mre [2];
    logic [FPW-1:0] mim [2];
    logic [1:0]     mvalid;
    logic [IW-1:0]  mit0, mit1;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mvalid <= 2'b00;
            for (int l = 0; l < 2; l++) begin
                mcnt[l] <= 0;
                mre[l]  <= '0;
                mim[l]  <= '0;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (eng_start[l]) begin
                    mcnt[l]   <= lat[l];
                    mvalid[l] <= 1'b0;
                    mre[l]    <= eng_c_real;
                    mim[l]    <= eng_c_imag;
                end else if (mcnt[l] > 1) begin
                    mcnt[l] <= mcnt[l] - 1;
                end else if (mcnt[l] == 1) begin
                    mcnt[l]   <= 0;
                    mvalid[l] <= 1'b1;
                end
            end
        end
    end

    assign mit0 = ovr[0] ? 8'hFF : (mre[0][15:8] ^ mim[0][15:8]);
    assign mit1 = ovr[1] ? 8'hFF : (mre[1][15:8] ^ mim[1][15:8]);
    assign eng_valid         = mvalid;
    assign eng_is_mandelbrot = ovr;
    assign eng_iterations    = {mit1, mit0};

    // Hand-computed expectations for x0=E000 dx=0400 y0=F000 dy=0800.
    logic [FPW-1:0] exp_re [4] = '{16'hE000, 16'hE400, 16'hE800, 16'hEC00};
    logic [FPW-1:0] exp_im [2] = '{16'hF000, 16'hF800};
    logic [IW-1:0]  exp_it [8] = '{8'h10, 8'h14, 8'h18, 8'h1C, 8'h18, 8'h1C, 8'h10, 8'h14};

    int checks = 0;
    int errors = 0;
    int issue_cnt, acc_cnt, done_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Observe the current cycle (issues, handshakes, frame_done) then advance to next negedge.
    task automatic step();
        int k;
        if (eng_start != 2'b00) begin
            k = issue_cnt;
            if (k < HR * VR) begin
                check("eng_start_lane", 32'(eng_start), (k % 2 == 0) ? 32'h1 : 32'h2);
                check("eng_c_real", 32'(eng_c_real), 32'(exp_re[k % HR]));
                check("eng_c_imag", 32'(eng_c_imag), 32'(exp_im[k / HR]));
                if (k >= 2) check("reissue_after_retire", 32'((acc_cnt + int'(pix_valid)) >= k - 1), 32'h1);
            end else begin
                check("issue_index_range", 32'(k), 32'(HR * VR - 1));
            end
            issue_cnt++;
        end
        if (pix_valid && pix_ready) begin
            k = acc_cnt;
            if (k < HR * VR) begin
                check("pix_x", 32'(pix_x), 32'(k % HR));
                check("pix_y", 32'(pix_y), 32'(k / HR));
                check("pix_last", 32'(pix_last), 32'(k == HR * VR - 1));
                check("pix_iterations", 32'(pix_iterations), ovr[k % 2] ? 32'hFF : 32'(exp_it[k]));
                check("pix_is_mandelbrot", 32'(pix_is_mandelbrot), 32'(ovr[k % 2]));
            end else begin
                check("pixel_index_range", 32'(k), 32'(HR * VR - 1));
            end
            acc_cnt++;
        end
        if (frame_done) begin
            done_cnt++;
            check("busy_at_done", 32'(busy), 32'h0);
            check("accepted_at_done", 32'(acc_cnt), 32'(HR * VR));
        end
        @(negedge clk);
    endtask

    task automatic start_frame(input logic [FPW-1:0] x0, input logic [FPW-1:0] y0,
                               input logic [FPW-1:0] dx, input logic [FPW-1:0] dy);
        issue_cnt = 0;
        acc_cnt   = 0;
        done_cnt  = 0;
        cfg_x0 = x0;
        cfg_y0 = y0;
        cfg_dx = dx;
        cfg_dy = dy;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        check("frame_done_seen", 32'(done_cnt), 32'h1);
        repeat (3) step();
        check("single_frame_done", 32'(done_cnt), 32'h1);
        check("issue_total", 32'(issue_cnt), 32'(HR * VR));
        check("accept_total", 32'(acc_cnt), 32'(HR * VR));
        check("idle_after_frame", 32'(busy), 32'h0);
    endtask

    initial begin
        lat[0] = 1;
        lat[1] = 1;
        issue_cnt = 0;
        acc_cnt   = 0;
        done_cnt  = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_eng_start", 32'(eng_start), 32'h0);
        check("rst_pix_valid", 32'(pix_valid), 32'h0);
        check("rst_pix_last", 32'(pix_last), 32'h0);
        check("rst_eng_c_real", 32'(eng_c_real), 32'h0);
        nrst = 1'b1;
        @(negedge clk);

        // T2: basic raster frame, immediate engines, no backpressure
        start_frame(16'hE000, 16'hF000, 16'h0400, 16'h0800);
        check("t2_busy_after_start", 32'(busy), 32'h1);
        check("t2_first_start_lane0", 32'(eng_start), 32'h1);
        run_to_done(200);

        // T3: lane0 slow, lane1 fast; raster order must hold
        lat[0] = 30;
        lat[1] = 2;
        start_frame(16'hE000, 16'hF000, 16'h0400, 16'h0800);
        run_to_done(600);
        lat[0] = 1;
        lat[1] = 1;

        // T4: 20 cycles of backpressure once (0,0) is waiting
        pix_ready = 1'b0;
        start_frame(16'hE000, 16'hF000, 16'h0400, 16'h0800);
        repeat (6) step();
        for (int i = 0; i < 20; i++) begin
            check("t4_hold_valid", 32'(pix_valid), 32'h1);
            check("t4_hold_x", 32'(pix_x), 32'h0);
            check("t4_hold_y", 32'(pix_y), 32'h0);
            check("t4_hold_iter", 32'(pix_iterations), 32'h10);
            step();
        end
        check("t4_outstanding_issues", 32'(issue_cnt), 32'h3);
        pix_ready = 1'b1;
        run_to_done(200);

        // T5: second frame_start with different cfg while running is ignored
        start_frame(16'hE000, 16'hF000, 16'h0400, 16'h0800);
        repeat (4) step();
        cfg_x0 = 16'h1234;
        cfg_y0 = 16'h5678;
        cfg_dx = 16'h0101;
        cfg_dy = 16'h0202;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("t5_still_busy", 32'(busy), 32'h1);
        run_to_done(200);

        // T1: asynchronous reset in the middle of a frame
        start_frame(16'hE000, 16'hF000, 16'h0400, 16'h0800);
        repeat (5) step();
        check("t1_pre_busy", 32'(busy), 32'h1);
        check("t1_pre_pix_valid", 32'(pix_valid), 32'h1);
        check("t1_pre_eng_start", 32'(eng_start), 32'h1);
        nrst = 1'b0;
        #1;
        check("t1_busy", 32'(busy), 32'h0);
        check("t1_pix_valid", 32'(pix_valid), 32'h0);
        check("t1_eng_start", 32'(eng_start), 32'h0);
        check("t1_frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // T6: lane0 reports in-set with FF iterations; also a clean frame after the abort
        ovr = 2'b01;
        start_frame(16'hE000, 16'hF000, 16'h0400, 16'h0800);
        run_to_done(200);
        ovr = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
